// File: rtl/denorm_shifter.sv
// -----------------------------------------------------------------------------
// denorm_shifter
//
// Two-stage pipelined right shifter. It undoes the leading-sign normalization
// that was applied to the division operands. Stage 1 applies the coarse part
// of the shift (a multiple of 8). Stage 2 applies the fine part (0..7). Both
// sides use a valid/ready handshake with full backpressure.
//
// Optional feature (macro DENORM_STICKY_EN):
//   When the macro is defined, o_sticky reports the OR of every bit shifted out.
//   When it is undefined, the sticky logic is absent and o_sticky is tied to 0.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   i_valid   upstream presents a transaction
//   i_ready   block can accept this cycle
//   i_data    normalized value
//   i_shift   right-shift amount, 0..DATA_W-1
//   i_signed  1 = arithmetic (sign fill), 0 = logical (zero fill)
//   o_valid   result available
//   o_ready   downstream accepts the result
//   o_data    shifted result
//   o_sticky  OR of all bits shifted out (0 without DENORM_STICKY_EN)
// -----------------------------------------------------------------------------
module denorm_shifter #(
    parameter int DATA_W  = 32,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_signed,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_sticky
);

    localparam int FINE_W = 3;

    // Pipeline registers
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [FINE_W-1:0] r_s1_fine;
    logic              r_s1_fill;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;

    // Handshake
    logic w_adv1;
    logic w_adv2;

    // Stage datapaths
    logic               w_fill;
    logic [SHIFT_W-1:0] w_coarse;
    logic [DATA_W-1:0]  w_s1_data;
    logic [DATA_W-1:0]  w_s2_data;

    // A stage may load when it is empty or when its contents move on this edge.
    assign w_adv2  = !r_s2_valid || o_ready;
    assign w_adv1  = !r_s1_valid || w_adv2;
    assign i_ready = w_adv1;

    // The fill bit is chosen once and carried along, so stage 2 uses the
    // original sign even after the coarse shift has moved bit 31 away.
    assign w_fill   = i_signed & i_data[DATA_W-1];
    assign w_coarse = {i_shift[SHIFT_W-1:FINE_W], {FINE_W{1'b0}}};

    // Shift a double-width word whose upper half is the fill bit, then keep
    // the low half. This gives a sign-fill or zero-fill shift in one expression.
    assign w_s1_data = DATA_W'({{DATA_W{w_fill}}, i_data} >> w_coarse);
    assign w_s2_data = DATA_W'({{DATA_W{r_s1_fill}}, r_s1_data} >> r_s1_fine);

`ifdef DENORM_STICKY_EN
    logic              r_s1_sticky;
    logic              r_s2_sticky;
    logic [DATA_W-1:0] w_s1_mask;
    logic [DATA_W-1:0] w_s2_mask;
    logic              w_s1_sticky;
    logic              w_s2_sticky;

    // The masks select the low bits that each stage discards.
    assign w_s1_mask   = ~({DATA_W{1'b1}} << w_coarse);
    assign w_s2_mask   = ~({DATA_W{1'b1}} << r_s1_fine);
    assign w_s1_sticky = |(i_data & w_s1_mask);
    assign w_s2_sticky = r_s1_sticky | (|(r_s1_data & w_s2_mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_sticky <= 1'b0;
        end else if (w_adv1 && i_valid) begin
            r_s1_sticky <= w_s1_sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_sticky <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
            r_s2_sticky <= w_s2_sticky;
        end
    end

    assign o_sticky = r_s2_sticky;
`else
    assign o_sticky = 1'b0;
`endif

    // Stage 1: coarse shift. Data loads only with a valid beat, so bubbles
    // never disturb what is already downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_fine  <= '0;
            r_s1_fill  <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_data <= w_s1_data;
                r_s1_fine <= i_shift[FINE_W-1:0];
                r_s1_fill <= w_fill;
            end
        end
    end

    // Stage 2: fine shift. This stage drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_data;
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_data  = r_s2_data;

endmodule

// File: tb/tb_denorm_shifter.sv
// -----------------------------------------------------------------------------
// tb_denorm_shifter
//
// Scoreboard bench for denorm_shifter. The driver pushes the expected result
// when a transaction is accepted. A separate monitor pops and compares
// whenever the DUT hands over a result.
// -----------------------------------------------------------------------------
module tb_denorm_shifter;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        i_valid  = 1'b0;
    logic        i_ready;
    logic [31:0] i_data   = '0;
    logic [4:0]  i_shift  = '0;
    logic        i_signed = 1'b0;
    logic        o_valid;
    logic        o_ready  = 1'b1;
    logic [31:0] o_data;
    logic        o_sticky;

    denorm_shifter #(.DATA_W(32), .SHIFT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .i_shift  (i_shift),
        .i_signed (i_signed),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_sticky (o_sticky)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_data_q[$];
    logic        exp_st_q[$];
    logic        seen_first = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_st    = 1'b0;
    logic        b2b_mode   = 1'b0;
    logic        have_prev  = 1'b0;
    int          last_out_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [4:0] s, input logic sg);
        logic [31:0] r;
        if (sg) r = $signed(d) >>> s;
        else    r = d >> s;
        return r;
    endfunction

    function automatic logic ref_sticky(input logic [31:0] d, input logic [4:0] s);
        logic [31:0] ones;
        ones = '1;
        return |(d & ~(ones << s));
    endfunction

    // Present one transaction and hold it until accepted. The expected result
    // is pushed just before the accepting edge.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic sg,
                        input logic [31:0] ed, input logic est);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        i_data   = d;
        i_shift  = s;
        i_signed = sg;
        i_valid  = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (i_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no i_ready for data %h, required acceptance", d);
        end else begin
            exp_data_q.push_back(ed);
`ifdef DENORM_STICKY_EN
            exp_st_q.push_back(est);
`else
            exp_st_q.push_back(1'b0);
`endif
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_ref(input logic [31:0] d, input logic [4:0] s, input logic sg);
        send(d, s, sg, ref_data(d, s, sg), ref_sticky(d, s));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_data_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_data_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_data_q.size());
            exp_data_q.delete();
            exp_st_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every handed-over result with the scoreboard head and
    // checks output stability during stalls.
    initial begin
        logic [31:0] ed;
        logic        es;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (!seen_first && !o_valid)
                    check("idle_o_data", o_data, 32'h0);
                if (o_valid) seen_first = 1'b1;
                if (prev_stall && o_valid) begin
                    check("stall_hold_data", o_data, prev_data);
                    check("stall_hold_sticky", {31'b0, o_sticky}, {31'b0, prev_st});
                end
                prev_stall = o_valid && !o_ready;
                prev_data  = o_data;
                prev_st    = o_sticky;
                if (o_valid && o_ready) begin
                    if (exp_data_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %h, required no result", o_data);
                    end else begin
                        ed = exp_data_q.pop_front();
                        es = exp_st_q.pop_front();
                        check("result_data", o_data, ed);
                        check("result_sticky", {31'b0, o_sticky}, {31'b0, es});
                    end
                    if (b2b_mode) begin
                        if (have_prev)
                            check("b2b_gap", 32'(cyc - last_out_cyc), 32'd1);
                        have_prev    = 1'b1;
                        last_out_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("reset_o_valid", {31'b0, o_valid}, 32'h0);
        check("reset_o_data", o_data, 32'h0);
        check("reset_o_sticky", {31'b0, o_sticky}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_i_ready", {31'b0, i_ready}, 32'h1);

        // Directed vectors with hand-computed results
        send(32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 1'b0);
        send(32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 1'b0);
        send(32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1);
        send(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001, 1'b1);
        send(32'hA5A5_1234, 5'd0,  1'b1, 32'hA5A5_1234, 1'b0);
        send(32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 1'b1);
        send(32'h1234_5678, 5'd12, 1'b0, 32'h0001_2345, 1'b1);
        send(32'h8765_4321, 5'd20, 1'b1, 32'hFFFF_F876, 1'b1);
        send(32'h0000_0013, 5'd2,  1'b0, 32'h0000_0004, 1'b1);
        send(32'h0000_0010, 5'd4,  1'b0, 32'h0000_0001, 1'b0);
        drain();

        // Backpressure: five back-to-back values, downstream stalls 4 cycles
        fork
            begin
                send(32'h1111_1111, 5'd1,  1'b0, 32'h0888_8888, 1'b1);
                send(32'h8000_0001, 5'd8,  1'b1, 32'hFF80_0000, 1'b1);
                send(32'h0000_FF00, 5'd8,  1'b0, 32'h0000_00FF, 1'b0);
                send(32'hF000_0000, 5'd28, 1'b1, 32'hFFFF_FFFF, 1'b0);
                send(32'h0123_4567, 5'd16, 1'b0, 32'h0000_0123, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                o_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("stall_i_ready", {31'b0, i_ready}, 32'h0);
                repeat (2) @(posedge clk);
                #1;
                o_ready = 1'b1;
            end
        join
        drain();

        // Back-to-back random vectors against a >>> / >> reference
        have_prev = 1'b0;
        b2b_mode  = 1'b1;
        for (int k = 0; k < 16; k++)
            send_ref($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        drain();
        b2b_mode = 1'b0;

        // Reset with two transactions in flight
        send_ref(32'hDEAD_BEEF, 5'd3, 1'b1);
        send_ref(32'hCAFE_F00D, 5'd9, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_o_valid", {31'b0, o_valid}, 32'h0);
        check("midreset_o_data", o_data, 32'h0);
        exp_data_q.delete();
        exp_st_q.delete();
        seen_first = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_partial_after_reset", {31'b0, o_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        send(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        check("latency_stage1", {31'b0, o_valid}, 32'h0);
        @(negedge clk);
        check("latency_stage2", {31'b0, o_valid}, 32'h1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/denorm_shifter.md
Name: denorm_shifter

Overview:
- Pipelined right shifter that undoes the leading-sign normalization applied to operands before the division core.
- Takes a 32-bit normalized value plus the normalization count and shifts it right by that count, arithmetic or logical.
- Sits between the division core's remainder/quotient output and the result formatting stage.
- Two register stages, valid/ready handshake on both sides, full backpressure support.

Parameters:
- DATA_W, 32, data width in bits; must be a power of two, 32 is the only verified value.
- SHIFT_W, 5, shift-count width; equals log2(DATA_W).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  upstream presents a transaction
- i_ready  output  1  block can accept this cycle
- i_data  input  DATA_W  normalized value
- i_shift  input  SHIFT_W  right-shift amount, 0..DATA_W-1
- i_signed  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill)
- o_valid  output  1  result available
- o_ready  input  1  downstream accepts result
- o_data  output  DATA_W  shifted result
- o_sticky  output  1  OR of all bits shifted out (only with DENORM_STICKY_EN; tied 0 otherwise)

Behaviour:
- Reset is asynchronous and active-low on rst_n. While rst_n is low, all stage registers clear: s1_valid=0, s2_valid=0, o_valid=0, o_data=0, o_sticky=0. i_ready=1 immediately after release.
- Stage 1 (coarse shift):
  - Registers the result shifted right by {i_shift[4:3],3'b0}, i.e. 0, 8, 16 or 24 bits.
  - Fill bit is i_data[31] when i_signed=1, else 0.
  - Also registers i_shift[2:0], the fill bit and the partial sticky.
- Stage 2 (fine shift):
  - Registers the stage-1 result shifted right by the stored 0..7, using the same stored fill bit.
  - The stage-2 register drives o_data, o_sticky and o_valid.
- Handshake:
  - A transfer occurs on any edge where valid&ready is high, on either side.
  - adv2 = !s2_valid | o_ready.
  - adv1 = !s1_valid | adv2.
  - i_ready = adv1 (combinational from register state and o_ready).
- Register updates:
  - Stage 1 loads when adv1. s1_valid <= i_valid.
  - Stage 2 loads when adv2. s2_valid <= s1_valid.
  - A stalled stage holds data and valid unchanged.
- Latency and throughput:
  - Latency is 2 cycles from the accepting edge to o_valid, with no backpressure.
  - Throughput is one result per cycle while o_ready=1.
- Output stability: while o_valid=1 and o_ready=0, o_data and o_sticky are held constant.
- Data registers load only on an advance. Bubbles (valid=0) may load don't-care data, but o_data must not change while o_valid=0 after reset until the first result. Implementation: gate data load with the incoming valid.
- Boundary cases:
  - i_shift=0 passes i_data unchanged, sticky=0.
  - i_shift=31 with i_signed=1 gives all-ones or all-zeros according to i_data[31].
- Simultaneous events:
  - Full pipe with o_ready=1 and i_valid=1: all three transfers happen on the same edge, no bubble.
  - Full pipe with o_ready=0: i_ready=0.
- Reset mid-operation: in-flight transactions are discarded and no partial result appears after reset.
- No combinational path from i_data or i_shift to any output.

Optional Feature:
- Macro: DENORM_STICKY_EN.
- Defined:
  - Stage 1 computes the OR of the bits discarded by the coarse shift.
  - Stage 2 ORs in the bits discarded by the fine shift.
  - o_sticky is 1 if any nonzero bit was shifted out, regardless of i_signed.
- Undefined: the sticky logic is removed and o_sticky is constant 0.

Test Plan:
- Reset: rst_n low mid-stream with 2 transactions in flight -> o_valid=0 and o_data=0 at once. After release the first result appears only 2 cycles after a new acceptance.
- Arithmetic: i_data=32'h8000_0000, i_shift=4, i_signed=1 -> o_data=32'hF800_0000. Same with i_signed=0 -> 32'h0800_0000.
- Full range: i_data=32'hFFFF_FFFF, i_shift=31, i_signed=1 -> 32'hFFFF_FFFF. i_signed=0 -> 32'h0000_0001. i_shift=0 -> input unchanged.
- Backpressure:
  - Stream 5 values, o_ready=0 for cycles 3-6.
  - i_ready drops once both stages are full.
  - o_data holds steady during the stall.
  - All 5 results arrive in order, none lost or duplicated.
- Back-to-back: i_valid=1 and o_ready=1 continuously for 16 random vectors -> 16 results on consecutive cycles after 2-cycle latency, each matching a reference >>> / >>.
- Sticky (DENORM_STICKY_EN): i_data=32'h0000_0013, i_shift=2 -> o_data=32'h4, o_sticky=1. i_data=32'h0000_0010, i_shift=4 -> o_sticky=0. Macro undefined -> o_sticky=0 always.
